ifu_fetch_buffer: RTL and testbench

- Instruction-fetch buffer between the PC register and the IF/ID boundary.
- Fetches from instruction memory at the current PC over a req/gnt/rvalid handshake, one request outstanding at a time.
- Drives the PC register's enable so the PC advances only when a fetch is granted.
- Queues fetched {pc, instr} pairs for decode (valid/ready) and discards everything on a control-flow redirect.

---
 rtl/ifu_fetch_buffer.sv | 117 +++++++++++
 tb/tb_ifu_fetch_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_buffer.sv
// Instruction-fetch buffer: issues one outstanding imem request at a time, gates
// the PC register enable on grant, and queues {pc, instr} pairs for decode.
module ifu_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [31:0]        pc_mem_q    [DEPTH];
  logic [31:0]        instr_mem_q [DEPTH];

  logic grant;
  logic push;
  logic pop;

  // Handshake decode and next-state logic
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    req_pc_d  = req_pc_q;

    imem_req  = (state_q == ST_IDLE) && (count_q < CNT_W'(DEPTH)) && !redirect && reset;
    imem_addr = pc_in;
    grant     = imem_req && imem_gnt;
    pc_en     = reset && (grant || redirect);
    push      = reset && (state_q == ST_WAIT) && imem_rvalid && !redirect;
    out_valid = (count_q != '0) && !redirect;
    pop       = out_valid && out_ready;

    case (state_q)
      ST_IDLE: if (grant) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid)   state_d = ST_IDLE;
        else if (redirect) state_d = ST_DROP;
      end
      ST_DROP: if (imem_rvalid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (grant) req_pc_d = pc_in;

    // A redirect flushes the queue; an in-flight response is dropped via ST_DROP
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Queue storage; contents are only observed through count_q, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign out_instr = (count_q != '0) ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign out_pc    = (count_q != '0) ? pc_mem_q[rd_ptr_q]    : RESET_PC;
  assign count     = count_q;

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// Directed bench for ifu_fetch_buffer: stimulus pushes expected {pc, instr} into a
// scoreboard queue, a negedge monitor pops and compares on every decode handshake.
module tb_ifu_fetch_buffer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in = RST_PC;
  logic        pc_en;
  logic        redirect;
  logic [31:0] redirect_tgt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;
  exp_t exp_q[$];

  ifu_fetch_buffer #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_en(pc_en), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  always #5 clk = ~clk;

  // PC register environment: loads nPC (pc+4 or redirect target) when pc_en=1
  always @(posedge clk) begin
    if (!reset)     pc_in <= RST_PC;
    else if (pc_en) pc_in <= redirect ? redirect_tgt : pc_in + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got pc %h instr %h expected nothing", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_pc", out_pc, e.pc);
        chk("pop_instr", out_instr, e.instr);
        pops++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge; returns one step after the edge following grant
  task automatic grant(input logic [31:0] exp_pc, input int wait_cyc);
    imem_gnt = 1'b0;
    #1;
    for (int i = 0; i < wait_cyc; i++) begin
      chk("hold_req", 32'(imem_req), 32'd1);
      chk("hold_addr", imem_addr, exp_pc);
      chk("hold_pc_en", 32'(pc_en), 32'd0);
      cyc();
      #1;
    end
    imem_gnt = 1'b1;
    #1;
    chk("grant_req", 32'(imem_req), 32'd1);
    chk("grant_addr", imem_addr, exp_pc);
    chk("grant_pc_en", 32'(pc_en), 32'd1);
    cyc();
    imem_gnt = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] data, input logic [31:0] pc, input bit do_push);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    #1;
    chk("wait_req", 32'(imem_req), 32'd0);
    chk("wait_pc_en", 32'(pc_en), 32'd0);
    if (do_push) exp_q.push_back('{pc: pc, instr: data});
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int gw);
    grant(pc, gw);
    rsp(data, pc, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((count != 3'd0 || exp_q.size() != 0) && n < 20) begin
      cyc();
      n++;
    end
    #1;
    chk(name, 32'(count), 32'd0);
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_tgt = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
    cyc(); cyc(); cyc();

    // Reset: nothing requested or enabled even with gnt/redirect high
    imem_gnt = 1'b1;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc_en_gnt", 32'(pc_en), 32'd0);
    redirect = 1'b1;
    #1;
    chk("rst_pc_en_redir", 32'(pc_en), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, RST_PC);
    chk("rst_out_instr", out_instr, 32'h0);
    imem_gnt = 1'b0;
    redirect = 1'b0;
    cyc();
    reset = 1'b1;

    // First fetch, immediate grant, response next cycle
    fetch(32'h3000, 32'h3C01_0001, 0);
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_pc", out_pc, 32'h3000);
    chk("t1_out_instr", out_instr, 32'h3C01_0001);
    chk("t1_count", 32'(count), 32'd1);
    cyc();

    // Grant held off for three cycles
    fetch(32'h3004, 32'h2402_0004, 3);

    // Fill to DEPTH with decode stalled
    fetch(32'h3008, 32'h0041_1820, 0);
    fetch(32'h300C, 32'hAC03_0000, 0);
    #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_req", 32'(imem_req), 32'd0);
    imem_gnt = 1'b1;
    #1;
    chk("full_pc_en", 32'(pc_en), 32'd0);
    cyc();
    imem_gnt = 1'b0;
    #1;
    chk("full_count_hold", 32'(count), 32'd4);
    chk("full_pc_hold", pc_in, 32'h3010);
    out_ready = 1'b1;
    #1;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    cyc();
    #1;
    chk("resume_count", 32'(count), 32'd3);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h3010);
    drain("drain1_count");

    // Simultaneous push and pop keeps count unchanged
    cyc();
    out_ready = 1'b0;
    fetch(32'h3010, 32'h1111_0010, 0);
    grant(32'h3014, 0);
    out_ready = 1'b1;
    rsp(32'h2222_0014, 32'h3014, 1'b1);
    out_ready = 1'b0;
    #1;
    chk("pushpop_count", 32'(count), 32'd1);
    chk("pushpop_head", out_pc, 32'h3014);
    cyc();

    // Redirect while a response is pending: queue flushed, late data dropped
    grant(32'h3018, 0);
    redirect = 1'b1;
    redirect_tgt = 32'h3040;
    #1;
    chk("redir_out_valid", 32'(out_valid), 32'd0);
    chk("redir_pc_en", 32'(pc_en), 32'd1);
    chk("redir_req", 32'(imem_req), 32'd0);
    cyc();
    redirect = 1'b0;
    exp_q.delete();
    #1;
    chk("drop_count", 32'(count), 32'd0);
    chk("drop_req", 32'(imem_req), 32'd0);
    chk("drop_pc", pc_in, 32'h3040);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("drop_rsp_req", 32'(imem_req), 32'd0);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("after_drop_count", 32'(count), 32'd0);
    chk("after_drop_req", 32'(imem_req), 32'd1);
    chk("after_drop_addr", imem_addr, 32'h3040);
    cyc();
    fetch(32'h3040, 32'h3333_0040, 0);

    // Redirect coincident with rvalid
    grant(32'h3044, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h4444_0044;
    redirect = 1'b1;
    redirect_tgt = 32'h3080;
    #1;
    chk("redir_rv_pc_en", 32'(pc_en), 32'd1);
    chk("redir_rv_out_valid", 32'(out_valid), 32'd0);
    chk("redir_rv_req", 32'(imem_req), 32'd0);
    cyc();
    imem_rvalid = 1'b0;
    redirect = 1'b0;
    exp_q.delete();
    #1;
    chk("redir_rv_count", 32'(count), 32'd0);
    chk("redir_rv_next_req", 32'(imem_req), 32'd1);
    chk("redir_rv_next_addr", imem_addr, 32'h3080);
    chk("redir_rv_empty_pc", out_pc, RST_PC);
    chk("redir_rv_empty_instr", out_instr, 32'h0);
    cyc();

    // Reset asserted in WAIT with two entries queued
    fetch(32'h3080, 32'h5555_0080, 0);
    fetch(32'h3084, 32'h6666_0084, 0);
    grant(32'h3088, 0);
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h7777_0088;
    #1;
    chk("rstw_req", 32'(imem_req), 32'd0);
    chk("rstw_pc_en", 32'(pc_en), 32'd0);
    cyc();
    #1;
    chk("rstw_count", 32'(count), 32'd0);
    chk("rstw_out_valid", 32'(out_valid), 32'd0);
    chk("rstw_out_pc", out_pc, RST_PC);
    cyc();
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h3000);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("rel_count", 32'(count), 32'd0);
    cyc();
    out_ready = 1'b1;
    fetch(32'h3000, 32'h8888_3000, 0);
    drain("final_count");
    chk("total_pops", 32'(pops), 32'd6);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
